// File: rtl/retry_local_rsm.sv
// Receive-side local retry state machine: tracks ESEQ, requests RETRY.Req on CRC
// errors, times out waiting for RETRY.Ack and escalates to PHY reinit and link abort.
module retry_local_rsm #(
    parameter int ESEQ_W = 8,
    parameter int CNT_W  = 5,
    parameter int TMO_W  = 13
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flit_valid,
    input  logic              i_crc_ok,
    input  logic              i_flit_is_ctrl,
    input  logic              i_retry_ack,
    input  logic              i_retry_req_sent,
    input  logic              i_pl_lnk_up,
    input  logic [3:0]        i_pl_state_sts,
    input  logic [CNT_W-1:0]  i_retry_threshold,
    input  logic [CNT_W-1:0]  i_reinit_threshold,
    input  logic [ESEQ_W-1:0] i_llr_wrap_value,
    input  logic [TMO_W-1:0]  i_retry_timeout_max,
    output logic              o_send_req_seq,
    output logic [ESEQ_W-1:0] o_eseq,
    output logic [CNT_W-1:0]  o_num_retry,
    output logic [CNT_W-1:0]  o_num_phy_reinit,
    output logic              o_discard_flits,
    output logic              o_phy_reinit_req,
    output logic              o_link_failure,
    output logic              o_retry_threshold_hit,
    output logic              o_reinit_threshold_hit,
    output logic [2:0]        o_state
);

    localparam logic [2:0] ST_NORMAL     = 3'd0;
    localparam logic [2:0] ST_LLRREQ     = 3'd1;
    localparam logic [2:0] ST_LOCAL_IDLE = 3'd2;
    localparam logic [2:0] ST_PHY_REINIT = 3'd3;
    localparam logic [2:0] ST_ABORT      = 3'd4;

    localparam logic [ESEQ_W-1:0] ESEQ_ONE = {{(ESEQ_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]    CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]  TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_r, state_nxt_s;
    logic [ESEQ_W-1:0] eseq_r, eseq_nxt_s;
    logic [CNT_W-1:0]  num_retry_r, num_retry_nxt_s;
    logic [CNT_W-1:0]  num_reinit_r, num_reinit_nxt_s;
    logic [TMO_W-1:0]  timer_r, timer_nxt_s, timer_inc_s;
    logic              phase_r, phase_nxt_s;   // 0: reinit requested, 1: waiting for link up
    logic              send_req_r, phy_reinit_req_r, link_failure_r;
    logic              retry_hit_r, reinit_hit_r, retry_hit_s, reinit_hit_s;
    logic              enter_reinit_s;
    logic [CNT_W-1:0]  retry_thr_s, reinit_thr_s;
    logic [TMO_W-1:0]  tmo_max_s;
    logic [CNT_W:0]    retry_plus_s, reinit_plus_s;

    // Zero-valued limits behave as one; widened increments avoid counter wrap.
    always_comb begin
        retry_thr_s   = (i_retry_threshold == {CNT_W{1'b0}}) ? CNT_ONE[CNT_W-1:0] : i_retry_threshold;
        reinit_thr_s  = (i_reinit_threshold == {CNT_W{1'b0}}) ? CNT_ONE[CNT_W-1:0] : i_reinit_threshold;
        tmo_max_s     = (i_retry_timeout_max == {TMO_W{1'b0}}) ? TMO_ONE : i_retry_timeout_max;
        retry_plus_s  = {1'b0, num_retry_r} + CNT_ONE;
        reinit_plus_s = {1'b0, num_reinit_r} + CNT_ONE;
        timer_inc_s   = (timer_r >= tmo_max_s) ? tmo_max_s : timer_r + TMO_ONE;
    end

    // Next-state and counter update logic.
    always_comb begin
        state_nxt_s      = state_r;
        eseq_nxt_s       = eseq_r;
        num_retry_nxt_s  = num_retry_r;
        num_reinit_nxt_s = num_reinit_r;
        timer_nxt_s      = timer_r;
        phase_nxt_s      = phase_r;
        retry_hit_s      = 1'b0;
        reinit_hit_s     = 1'b0;
        enter_reinit_s   = 1'b0;
        case (state_r)
            ST_NORMAL: begin
                if (!i_pl_lnk_up) begin
                    state_nxt_s = ST_LLRREQ;
                end else if (i_flit_valid && !i_crc_ok) begin
                    state_nxt_s = ST_LLRREQ;
                end else if (i_flit_valid && !i_flit_is_ctrl) begin
                    eseq_nxt_s = (eseq_r == i_llr_wrap_value) ? {ESEQ_W{1'b0}} : eseq_r + ESEQ_ONE;
                end else begin
                    eseq_nxt_s = eseq_r;
                end
            end
            ST_LLRREQ: begin
                if (!i_pl_lnk_up) begin
                    enter_reinit_s = 1'b1;
                end else if (i_retry_req_sent) begin
                    state_nxt_s = ST_LOCAL_IDLE;
                    timer_nxt_s = {TMO_W{1'b0}};
                end else begin
                    state_nxt_s = ST_LLRREQ;
                end
            end
            ST_LOCAL_IDLE: begin
                if (!i_pl_lnk_up) begin
                    enter_reinit_s = 1'b1;
                end else if (i_retry_ack) begin
                    state_nxt_s      = ST_NORMAL;
                    num_retry_nxt_s  = {CNT_W{1'b0}};
                    num_reinit_nxt_s = {CNT_W{1'b0}};
                    timer_nxt_s      = {TMO_W{1'b0}};
                end else if (i_flit_valid) begin
                    timer_nxt_s = timer_inc_s;
                    if (timer_inc_s == tmo_max_s) begin
                        if (retry_plus_s >= {1'b0, retry_thr_s}) begin
                            enter_reinit_s  = 1'b1;
                            num_retry_nxt_s = {CNT_W{1'b0}};
                            retry_hit_s     = 1'b1;
                        end else begin
                            num_retry_nxt_s = retry_plus_s[CNT_W-1:0];
                            state_nxt_s     = ST_LLRREQ;
                        end
                    end else begin
                        state_nxt_s = ST_LOCAL_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_LOCAL_IDLE;
                end
            end
            ST_PHY_REINIT: begin
                if (!phase_r) begin
                    if (i_pl_state_sts == 4'b0000) begin
                        phase_nxt_s = 1'b1;
                    end else begin
                        phase_nxt_s = 1'b0;
                    end
                end else if (i_pl_lnk_up && (i_pl_state_sts != 4'b0000)) begin
                    state_nxt_s = ST_LLRREQ;
                end else begin
                    state_nxt_s = ST_PHY_REINIT;
                end
            end
            ST_ABORT: begin
                state_nxt_s = ST_ABORT;
            end
            default: begin
                state_nxt_s = ST_NORMAL;
            end
        endcase

        // Entering reinit always bumps the reinit count and may escalate straight to abort.
        if (enter_reinit_s) begin
            num_reinit_nxt_s = reinit_plus_s[CNT_W] ? {CNT_W{1'b1}} : reinit_plus_s[CNT_W-1:0];
            phase_nxt_s      = 1'b0;
            if (reinit_plus_s >= {1'b0, reinit_thr_s}) begin
                state_nxt_s  = ST_ABORT;
                reinit_hit_s = 1'b1;
            end else begin
                state_nxt_s  = ST_PHY_REINIT;
            end
        end else begin
            reinit_hit_s = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r          <= ST_NORMAL;
            eseq_r           <= {ESEQ_W{1'b0}};
            num_retry_r      <= {CNT_W{1'b0}};
            num_reinit_r     <= {CNT_W{1'b0}};
            timer_r          <= {TMO_W{1'b0}};
            phase_r          <= 1'b0;
            send_req_r       <= 1'b0;
            phy_reinit_req_r <= 1'b0;
            link_failure_r   <= 1'b0;
            retry_hit_r      <= 1'b0;
            reinit_hit_r     <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            eseq_r           <= eseq_nxt_s;
            num_retry_r      <= num_retry_nxt_s;
            num_reinit_r     <= num_reinit_nxt_s;
            timer_r          <= timer_nxt_s;
            phase_r          <= phase_nxt_s;
            send_req_r       <= (state_nxt_s == ST_LLRREQ);
            phy_reinit_req_r <= (state_nxt_s == ST_PHY_REINIT) && !phase_nxt_s;
            link_failure_r   <= (state_nxt_s == ST_ABORT);
            retry_hit_r      <= retry_hit_s;
            reinit_hit_r     <= reinit_hit_s;
        end
    end

    assign o_send_req_seq         = send_req_r;
    assign o_eseq                 = eseq_r;
    assign o_num_retry            = num_retry_r;
    assign o_num_phy_reinit       = num_reinit_r;
    assign o_discard_flits        = (state_r != ST_NORMAL);
    assign o_phy_reinit_req       = phy_reinit_req_r;
    assign o_link_failure         = link_failure_r;
    assign o_retry_threshold_hit  = retry_hit_r;
    assign o_reinit_threshold_hit = reinit_hit_r;
    assign o_state                = state_r;

endmodule

// File: tb/tb_retry_local_rsm.sv
// Directed self-checking bench for retry_local_rsm with hand-computed expectations.
module tb_retry_local_rsm;

    logic        i_clk = 1'b0;
    logic        i_rst, i_flit_valid, i_crc_ok, i_flit_is_ctrl;
    logic        i_retry_ack, i_retry_req_sent, i_pl_lnk_up;
    logic [3:0]  i_pl_state_sts;
    logic [4:0]  i_retry_threshold, i_reinit_threshold;
    logic [7:0]  i_llr_wrap_value;
    logic [12:0] i_retry_timeout_max;
    logic        o_send_req_seq, o_discard_flits, o_phy_reinit_req, o_link_failure;
    logic        o_retry_threshold_hit, o_reinit_threshold_hit;
    logic [7:0]  o_eseq;
    logic [4:0]  o_num_retry, o_num_phy_reinit;
    logic [2:0]  o_state;

    int n_checks = 0;
    int n_pass   = 0;

    retry_local_rsm dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flit_valid(i_flit_valid), .i_crc_ok(i_crc_ok),
        .i_flit_is_ctrl(i_flit_is_ctrl), .i_retry_ack(i_retry_ack),
        .i_retry_req_sent(i_retry_req_sent), .i_pl_lnk_up(i_pl_lnk_up),
        .i_pl_state_sts(i_pl_state_sts), .i_retry_threshold(i_retry_threshold),
        .i_reinit_threshold(i_reinit_threshold), .i_llr_wrap_value(i_llr_wrap_value),
        .i_retry_timeout_max(i_retry_timeout_max), .o_send_req_seq(o_send_req_seq),
        .o_eseq(o_eseq), .o_num_retry(o_num_retry), .o_num_phy_reinit(o_num_phy_reinit),
        .o_discard_flits(o_discard_flits), .o_phy_reinit_req(o_phy_reinit_req),
        .o_link_failure(o_link_failure), .o_retry_threshold_hit(o_retry_threshold_hit),
        .o_reinit_threshold_hit(o_reinit_threshold_hit), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_pulse();
        i_retry_req_sent = 1'b1;
        tick();
        i_retry_req_sent = 1'b0;
    endtask

    task automatic flits(input int n);
        i_flit_valid = 1'b1;
        i_crc_ok     = 1'b1;
        for (int k = 0; k < n; k++) tick();
        i_flit_valid = 1'b0;
    endtask

    task automatic crc_error();
        i_flit_valid = 1'b1;
        i_crc_ok     = 1'b0;
        tick();
        i_flit_valid = 1'b0;
        i_crc_ok     = 1'b1;
    endtask

    logic       ctrl_seq [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] eseq_exp [7] = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd0, 8'd1};

    initial begin
        i_rst = 1'b1; i_flit_valid = 1'b0; i_crc_ok = 1'b1; i_flit_is_ctrl = 1'b0;
        i_retry_ack = 1'b0; i_retry_req_sent = 1'b0; i_pl_lnk_up = 1'b1;
        i_pl_state_sts = 4'hF; i_retry_threshold = 5'd3; i_reinit_threshold = 5'd2;
        i_llr_wrap_value = 8'd3; i_retry_timeout_max = 13'd4;
        tick(); tick();
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_eseq", 32'(o_eseq), 32'd0);
        check("rst_send", 32'(o_send_req_seq), 32'd0);
        check("rst_discard", 32'(o_discard_flits), 32'd0);
        check("rst_fail", 32'(o_link_failure), 32'd0);
        i_rst = 1'b0;

        // ESEQ wrap at 3 with interleaved control flits
        for (int k = 0; k < 7; k++) begin
            i_flit_valid = 1'b1; i_crc_ok = 1'b1; i_flit_is_ctrl = ctrl_seq[k];
            tick();
            check($sformatf("wrap_eseq%0d", k), 32'(o_eseq), 32'(eseq_exp[k]));
        end
        i_flit_valid = 1'b0; i_flit_is_ctrl = 1'b0;

        // Bring ESEQ to 5, then CRC error / sent / ack
        i_llr_wrap_value = 8'd255;
        flits(4);
        check("eseq5", 32'(o_eseq), 32'd5);
        crc_error();
        check("crc_state", 32'(o_state), 32'd1);
        check("crc_send", 32'(o_send_req_seq), 32'd1);
        check("crc_eseq", 32'(o_eseq), 32'd5);
        check("crc_discard", 32'(o_discard_flits), 32'd1);
        tick();
        check("send_held", 32'(o_send_req_seq), 32'd1);
        send_pulse();
        check("sent_state", 32'(o_state), 32'd2);
        check("sent_send", 32'(o_send_req_seq), 32'd0);
        i_retry_ack = 1'b1; tick(); i_retry_ack = 1'b0;
        check("ack_state", 32'(o_state), 32'd0);
        check("ack_retry", 32'(o_num_retry), 32'd0);
        check("ack_discard", 32'(o_discard_flits), 32'd0);

        // Timeouts: max=4, threshold=3
        crc_error();
        send_pulse();
        flits(3);
        check("tmo_pending", 32'(o_state), 32'd2);
        flits(1);
        check("tmo1_state", 32'(o_state), 32'd1);
        check("tmo1_retry", 32'(o_num_retry), 32'd1);
        send_pulse();
        flits(4);
        check("tmo2_retry", 32'(o_num_retry), 32'd2);
        send_pulse();
        flits(4);
        check("tmo3_hit", 32'(o_retry_threshold_hit), 32'd1);
        check("tmo3_state", 32'(o_state), 32'd3);
        check("tmo3_retry", 32'(o_num_retry), 32'd0);
        check("tmo3_reinit", 32'(o_num_phy_reinit), 32'd1);
        check("tmo3_req", 32'(o_phy_reinit_req), 32'd1);
        check("tmo3_eseq", 32'(o_eseq), 32'd5);
        tick();
        check("tmo3_hit_pulse", 32'(o_retry_threshold_hit), 32'd0);

        // Reinit handshake
        i_pl_state_sts = 4'h0; tick();
        check("phyA_req", 32'(o_phy_reinit_req), 32'd0);
        check("phyA_state", 32'(o_state), 32'd3);
        i_pl_lnk_up = 1'b0; tick();
        check("phyB_wait", 32'(o_state), 32'd3);
        i_pl_lnk_up = 1'b1; i_pl_state_sts = 4'hF; tick();
        check("phyB_state", 32'(o_state), 32'd1);
        check("phyB_send", 32'(o_send_req_seq), 32'd1);

        // Second reinit via link loss -> abort
        i_pl_lnk_up = 1'b0; tick(); i_pl_lnk_up = 1'b1;
        check("abort_state", 32'(o_state), 32'd4);
        check("abort_hit", 32'(o_reinit_threshold_hit), 32'd1);
        check("abort_fail", 32'(o_link_failure), 32'd1);
        check("abort_reinit", 32'(o_num_phy_reinit), 32'd2);
        i_retry_ack = 1'b1; tick(); tick(); i_retry_ack = 1'b0;
        check("abort_sticky", 32'(o_link_failure), 32'd1);
        check("abort_stay", 32'(o_state), 32'd4);
        check("abort_hit_pulse", 32'(o_reinit_threshold_hit), 32'd0);
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        check("rst2_state", 32'(o_state), 32'd0);
        check("rst2_fail", 32'(o_link_failure), 32'd0);
        check("rst2_reinit", 32'(o_num_phy_reinit), 32'd0);
        check("rst2_eseq", 32'(o_eseq), 32'd0);
        check("rst2_discard", 32'(o_discard_flits), 32'd0);

        // Ack coincident with timeout
        crc_error();
        send_pulse();
        flits(4);
        check("coinc_pre", 32'(o_num_retry), 32'd1);
        send_pulse();
        flits(3);
        i_retry_ack = 1'b1; flits(1); i_retry_ack = 1'b0;
        check("coinc_state", 32'(o_state), 32'd0);
        check("coinc_retry", 32'(o_num_retry), 32'd0);
        check("coinc_hit", 32'(o_retry_threshold_hit), 32'd0);

        // Zero thresholds/timeout behave as 1
        i_retry_threshold = 5'd0; i_retry_timeout_max = 13'd0; i_reinit_threshold = 5'd5;
        crc_error();
        send_pulse();
        flits(1);
        check("zero_state", 32'(o_state), 32'd3);
        check("zero_hit", 32'(o_retry_threshold_hit), 32'd1);
        check("zero_reinit", 32'(o_num_phy_reinit), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/retry_local_rsm.md
Name: retry_local_rsm

Overview:
Receive-side Local Retry State Machine (LRSM) for the CXL link-layer retry path. It checks incoming flits, keeps the expected sequence number (ESEQ) and, on a CRC error, asks the packer to send RETRY.Req. It then waits for RETRY.Ack under a flit-count timeout and escalates to PHY reinit, then link abort. It is the requester counterpart of the transmit-side retry buffer/responder and sits between the unpacker, the control-flit packer, the physical layer and the register file.

Parameters:
ESEQ_W, 8, width of ESEQ / wrap value
CNT_W, 5, width of retry / reinit counters and thresholds
TMO_W, 13, width of timeout counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_flit_valid  in  1  unpacker flit strobe, one flit per cycle
i_crc_ok  in  1  CRC of current flit good; qualified by i_flit_valid
i_flit_is_ctrl  in  1  current flit is control (does not consume ESEQ)
i_retry_ack  in  1  RETRY.Ack received with good CRC (1-cycle pulse)
i_retry_req_sent  in  1  packer has transmitted RETRY.Req (1-cycle pulse)
i_pl_lnk_up  in  1  physical layer up
i_pl_state_sts  in  4  PHY status; 4'b0000 = PHY in reinit
i_retry_threshold  in  CNT_W  max RETRY.Req attempts before reinit
i_reinit_threshold  in  CNT_W  max PHY reinits before abort
i_llr_wrap_value  in  ESEQ_W  ESEQ wrap value
i_retry_timeout_max  in  TMO_W  timeout, in received flits
o_send_req_seq  out  1  request packer to send RETRY.Req
o_eseq  out  ESEQ_W  ESEQ, carried in RETRY.Req
o_num_retry  out  CNT_W  current NUM_RETRY
o_num_phy_reinit  out  CNT_W  current NUM_PHY_REINIT
o_discard_flits  out  1  unpacker must drop received flits
o_phy_reinit_req  out  1  request PHY reinit
o_link_failure  out  1  link failure, sticky
o_retry_threshold_hit  out  1  1-cycle pulse
o_reinit_threshold_hit  out  1  1-cycle pulse
o_state  out  3  0 NORMAL, 1 LLRREQ, 2 LOCAL_IDLE, 3 PHY_REINIT, 4 ABORT

Behaviour:
- Reset (i_rst=1 at an i_clk edge, wins over all else): state NORMAL, eseq/counters/timer 0, all outputs 0. A mid-retry reset returns to NORMAL in the next cycle.
- Threshold or timeout input of 0 is treated as 1.
- o_discard_flits = (state != NORMAL), combinational from state.
- NORMAL:
  - valid & crc_ok & !is_ctrl: eseq <= (eseq == wrap) ? 0 : eseq+1.
  - valid & !crc_ok: go to LLRREQ; eseq frozen, flit not counted.
- LLRREQ: o_send_req_seq=1 (registered, asserted the cycle state==LLRREQ), held until i_retry_req_sent. On the sent pulse: go to LOCAL_IDLE and clear the timer; o_send_req_seq drops the same edge.
- LOCAL_IDLE:
  - Timer increments on each i_flit_valid, saturating at max.
  - i_retry_ack: go to NORMAL; clear num_retry, num_phy_reinit and timer.
  - Timeout is when the next incremented timer equals max. On timeout:
    - If num_retry+1 >= threshold: go to PHY_REINIT, num_retry <= 0, pulse o_retry_threshold_hit.
    - Else: num_retry++, go to LLRREQ.
  - Ack and timeout in the same cycle: ack wins.
- Link loss: i_pl_lnk_up=0 in LLRREQ or LOCAL_IDLE goes to PHY_REINIT without changing num_retry. In NORMAL it forces LLRREQ (eseq held).
- PHY_REINIT entry: num_phy_reinit++. If the new value >= reinit threshold, go to ABORT instead and pulse o_reinit_threshold_hit.
- PHY_REINIT phases:
  - Phase A: o_phy_reinit_req=1 until i_pl_state_sts==0.
  - Phase B: req=0; wait for i_pl_lnk_up=1 and i_pl_state_sts!=0, then go to LLRREQ.
- ABORT: o_link_failure=1, discard=1; all inputs ignored until reset.
- Counters never wrap. Pulses are registered, aligned with the state change. o_eseq is constant while not in NORMAL.

Test Plan:
- Wrap: wrap=3; 5 good data flits plus 2 control flits -> o_eseq sequence 1,2,3,0,1; control flits leave it unchanged.
- CRC error with ESEQ=5 -> next cycle o_state=1, o_send_req_seq=1, o_eseq=5. Sent pulse -> state 2. Ack -> state 0, o_num_retry=0, discard drops.
- Timeout: max=4, threshold=3; no ack, continuous flits -> num_retry 1, 2. Third timeout -> o_retry_threshold_hit pulse, state 3, num_retry=0, num_phy_reinit=1, o_phy_reinit_req=1.
- Reinit handshake: i_pl_state_sts=0 -> req drops. Then lnk_up=1 with sts=4'hF -> state 1.
- Abort: reinit_threshold=2; drive a second reinit -> o_reinit_threshold_hit pulse, state 4, o_link_failure stays 1 despite ack pulses. Assert i_rst -> all outputs 0.
- Ack and timeout in the same cycle -> state 0, no counter increment.
